// File: rtl/halton_pkg.sv
// Shared Halton definitions: default radices/digit counts matching the point
// generator, decoder FSM states, and an elaboration-time integer power helper.
package halton_pkg;

  localparam int DEF_BASE_0  = 2;
  localparam int DEF_BASE_1  = 3;
  localparam int DEF_SCALE_0 = 11;
  localparam int DEF_SCALE_1 = 7;

  // Wide enough for any legal digit count (BASE >= 2 and BASE^SCALE <= 2^32 give SCALE <= 32)
  localparam int N_W = 6;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RUN  = 2'd1,
    ST_DONE = 2'd2
  } state_e;

  function automatic longint unsigned ipow(input int unsigned base, input int unsigned exp);
    longint unsigned acc;
    acc = 64'd1;
    for (int unsigned i = 0; i < exp; i++) begin
      acc = acc * longint'(base);
    end
    return acc;
  endfunction

endpackage

// File: rtl/vdc_digit_unpacker.sv
// One Halton channel: peels the least-significant radix-BASE digit off the
// residue each step and appends it to the accumulator, reversing digit order.
module vdc_digit_unpacker
  import halton_pkg::*;
#(
  parameter int BASE  = DEF_BASE_0,
  parameter int SCALE = DEF_SCALE_0
) (
  input  logic           clk,
  input  logic           rst_n,
  input  logic           load_i,
  input  logic           step_i,
  input  logic [N_W-1:0] n_i,
  input  logic [31:0]    point_i,
  output logic [31:0]    index_o,
  output logic           residue_nz_o
);

  if (BASE < 2 || ipow(BASE, SCALE) > 64'h0000_0001_0000_0000) begin : g_param_chk
    $error("vdc_digit_unpacker: need BASE >= 2 and BASE**SCALE <= 2**32");
  end

  localparam logic [31:0]    BASE_W  = 32'(BASE);
  localparam logic [N_W-1:0] SCALE_N = N_W'(SCALE);

  logic [31:0] res_q, res_d;
  logic [31:0] acc_q, acc_d;
  logic        active_s;

  assign active_s = step_i && (n_i < SCALE_N);

  // Constant-divisor mod/div: synthesizes to fixed logic, one digit per cycle
  always_comb begin
    res_d = res_q;
    acc_d = acc_q;
    if (load_i) begin
      res_d = point_i;
      acc_d = 32'd0;
    end else if (active_s) begin
      acc_d = (acc_q * BASE_W) + (res_q % BASE_W);
      res_d = res_q / BASE_W;
    end else begin
      res_d = res_q;
      acc_d = acc_q;
    end
  end

  // Residue and accumulator registers
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      res_q <= 32'd0;
      acc_q <= 32'd0;
    end else begin
      res_q <= res_d;
      acc_q <= acc_d;
    end
  end

  assign index_o      = acc_q;
  assign residue_nz_o = (res_q != 32'd0);

endmodule

// File: rtl/halton_index_decoder.sv
// Recovers the integer sequence index of each channel of a two-channel
// Halton point, flags channel disagreement and out-of-range inputs.
module halton_index_decoder
  import halton_pkg::*;
#(
  parameter int BASE_0  = DEF_BASE_0,
  parameter int BASE_1  = DEF_BASE_1,
  parameter int SCALE_0 = DEF_SCALE_0,
  parameter int SCALE_1 = DEF_SCALE_1
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        in_valid,
  output logic        in_ready,
  input  logic [31:0] in_point_0,
  input  logic [31:0] in_point_1,
  output logic        out_valid,
  input  logic        out_ready,
  output logic [31:0] out_index_0,
  output logic [31:0] out_index_1,
  output logic        out_match,
  output logic        out_range_err
);

  localparam int             SMAX   = (SCALE_0 > SCALE_1) ? SCALE_0 : SCALE_1;
  localparam logic [N_W-1:0] N_LAST = N_W'(SMAX - 1);

  state_e         state_q, state_d;
  logic [N_W-1:0] n_q, n_d;
  logic           in_ready_q, in_ready_d;
  logic           out_valid_q, out_valid_d;
  logic           load_s, step_s;
  logic           nz0_s, nz1_s;

  // Next-state, step counter and handshake decode
  always_comb begin
    state_d = state_q;
    n_d     = n_q;
    load_s  = 1'b0;
    step_s  = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (in_valid) begin
          load_s  = 1'b1;
          n_d     = {N_W{1'b0}};
          state_d = ST_RUN;
        end else begin
          state_d = ST_IDLE;
        end
      end
      ST_RUN: begin
        step_s = 1'b1;
        n_d    = n_q + N_W'(1);
        if (n_q == N_LAST) begin
          state_d = ST_DONE;
        end else begin
          state_d = ST_RUN;
        end
      end
      ST_DONE: begin
        if (out_ready) begin
          state_d = ST_IDLE;
        end else begin
          state_d = ST_DONE;
        end
      end
      default: begin
        state_d = ST_IDLE;
        n_d     = {N_W{1'b0}};
      end
    endcase
    in_ready_d  = (state_d == ST_IDLE);
    out_valid_d = (state_d == ST_DONE);
  end

  // FSM, counter and registered handshake flags
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= ST_IDLE;
      n_q         <= {N_W{1'b0}};
      in_ready_q  <= 1'b1;
      out_valid_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      n_q         <= n_d;
      in_ready_q  <= in_ready_d;
      out_valid_q <= out_valid_d;
    end
  end

  vdc_digit_unpacker #(.BASE(BASE_0), .SCALE(SCALE_0)) u_ch0 (
    .clk          (clk),
    .rst_n        (rst_n),
    .load_i       (load_s),
    .step_i       (step_s),
    .n_i          (n_q),
    .point_i      (in_point_0),
    .index_o      (out_index_0),
    .residue_nz_o (nz0_s)
  );

  vdc_digit_unpacker #(.BASE(BASE_1), .SCALE(SCALE_1)) u_ch1 (
    .clk          (clk),
    .rst_n        (rst_n),
    .load_i       (load_s),
    .step_i       (step_s),
    .n_i          (n_q),
    .point_i      (in_point_1),
    .index_o      (out_index_1),
    .residue_nz_o (nz1_s)
  );

  assign in_ready      = in_ready_q;
  assign out_valid     = out_valid_q;
  assign out_match     = (out_index_0 == out_index_1);
  assign out_range_err = nz0_s | nz1_s;

endmodule

// File: tb/tb_halton_index_decoder.sv
// Self-checking bench for halton_index_decoder: directed test-plan points,
// backpressure, mid-run reset, back-to-back and randomized points vs a digit model.
module tb_halton_index_decoder;

  localparam int B0 = 2, B1 = 3, S0 = 11, S1 = 7;
  localparam int SMAX = 11;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        in_valid = 1'b0;
  logic        in_ready;
  logic [31:0] in_point_0 = 32'd0;
  logic [31:0] in_point_1 = 32'd0;
  logic        out_valid;
  logic        out_ready = 1'b0;
  logic [31:0] out_index_0, out_index_1;
  logic        out_match, out_range_err;

  int n_checks = 0;
  int n_errors = 0;

  halton_index_decoder dut (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
    .in_point_0(in_point_0), .in_point_1(in_point_1),
    .out_valid(out_valid), .out_ready(out_ready),
    .out_index_0(out_index_0), .out_index_1(out_index_1),
    .out_match(out_match), .out_range_err(out_range_err)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
    end
  endtask

  function automatic longint unsigned pw(input longint unsigned b, input int e);
    longint unsigned r = 64'd1;
    for (int i = 0; i < e; i++) r = r * b;
    return r;
  endfunction

  // Index = digits of the point read in the opposite order (radical inverse undone)
  function automatic logic [31:0] ref_index(input logic [31:0] x, input longint unsigned b, input int s);
    longint unsigned v, k, d;
    v = {32'd0, x} % pw(b, s);
    k = 64'd0;
    for (int i = 0; i < s; i++) begin
      d = (v / pw(b, s - 1 - i)) % b;
      k = k + d * pw(b, i);
    end
    return k[31:0];
  endfunction

  function automatic logic ref_err(input logic [31:0] x0, input logic [31:0] x1);
    return ({32'd0, x0} >= pw(64'd2, S0)) || ({32'd0, x1} >= pw(64'd3, S1));
  endfunction

  task automatic wait_ready();
    int t = 0;
    while (!in_ready && t < 50) begin
      @(negedge clk);
      t++;
    end
    if (!in_ready) chk("in_ready_timeout", {63'd0, in_ready}, 64'd1);
  endtask

  task automatic accept(input logic [31:0] p0, input logic [31:0] p1);
    wait_ready();
    in_valid   = 1'b1;
    in_point_0 = p0;
    in_point_1 = p1;
    @(posedge clk);
    @(negedge clk);
    in_valid   = 1'b0;
    in_point_0 = $urandom;
    in_point_1 = $urandom;
  endtask

  task automatic wait_done();
    int lat = 0;
    while (!out_valid && lat < 40) begin
      @(negedge clk);
      lat++;
    end
    chk("latency", 64'(lat), 64'(SMAX));
  endtask

  task automatic check_result(input string tag, input logic [31:0] k0, input logic [31:0] k1,
                              input logic m, input logic e);
    chk({tag, ".idx0"}, {32'd0, out_index_0}, {32'd0, k0});
    chk({tag, ".idx1"}, {32'd0, out_index_1}, {32'd0, k1});
    chk({tag, ".match"}, {63'd0, out_match}, {63'd0, m});
    chk({tag, ".rerr"}, {63'd0, out_range_err}, {63'd0, e});
  endtask

  task automatic release_result(input int hold);
    repeat (hold) @(negedge clk);
    out_ready = 1'b1;
    @(negedge clk);
    out_ready = 1'b0;
    chk("in_ready_after_pop", {63'd0, in_ready}, 64'd1);
  endtask

  logic [31:0] dp0 [10] = '{32'd1024, 32'd512, 32'd1536, 32'd256, 32'd1280,
                            32'd1024, 32'd0, 32'd2048, 32'd0, 32'd2047};
  logic [31:0] dp1 [10] = '{32'd729, 32'd1458, 32'd243, 32'd972, 32'd1701,
                            32'd1458, 32'd0, 32'd0, 32'd2187, 32'd2186};
  logic [31:0] dk0 [10] = '{32'd1, 32'd2, 32'd3, 32'd4, 32'd5, 32'd1, 32'd0, 32'd0, 32'd0, 32'd2047};
  logic [31:0] dk1 [10] = '{32'd1, 32'd2, 32'd3, 32'd4, 32'd5, 32'd2, 32'd0, 32'd0, 32'd0, 32'd2186};
  logic        dm  [10] = '{1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 1'b0, 1'b1, 1'b1, 1'b1, 1'b0};
  logic        de  [10] = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0};

  initial begin
    logic [31:0] p0, p1, k0, k1;
    logic [31:0] bq0 [3];
    logic [31:0] bq1 [3];
    int acc_cyc [3];
    int sent, got, cyc;

    // Reset state while rst_n is held low
    repeat (2) @(negedge clk);
    chk("rst.out_valid", {63'd0, out_valid}, 64'd0);
    chk("rst.in_ready", {63'd0, in_ready}, 64'd1);
    chk("rst.idx0", {32'd0, out_index_0}, 64'd0);
    chk("rst.idx1", {32'd0, out_index_1}, 64'd0);
    chk("rst.match", {63'd0, out_match}, 64'd1);
    chk("rst.rerr", {63'd0, out_range_err}, 64'd0);
    rst_n = 1'b1;
    @(negedge clk);

    // Directed points: round trip, mismatch, range edges
    for (int i = 0; i < 10; i++) begin
      accept(dp0[i], dp1[i]);
      wait_done();
      check_result($sformatf("dir%0d", i), dk0[i], dk1[i], dm[i], de[i]);
      release_result(0);
    end

    // Backpressure: result held stable, stray in_valid dropped
    accept(32'd1280, 32'd1701);
    wait_done();
    for (int c = 0; c < 5; c++) begin
      in_valid   = (c == 2);
      in_point_0 = 32'd1024;
      in_point_1 = 32'd1458;
      check_result($sformatf("bp%0d", c), 32'd5, 32'd5, 1'b1, 1'b0);
      chk("bp.in_ready", {63'd0, in_ready}, 64'd0);
      chk("bp.out_valid", {63'd0, out_valid}, 64'd1);
      @(negedge clk);
    end
    in_valid = 1'b0;
    release_result(0);
    chk("bp.valid_after_pop", {63'd0, out_valid}, 64'd0);
    accept(32'd512, 32'd1458);
    wait_done();
    check_result("bp.next", 32'd2, 32'd2, 1'b1, 1'b0);
    release_result(0);

    // Reset in the middle of digit extraction
    accept(32'd2047, 32'd2186);
    repeat (3) @(negedge clk);
    rst_n = 1'b0;
    #1;
    chk("mrst.out_valid", {63'd0, out_valid}, 64'd0);
    chk("mrst.in_ready", {63'd0, in_ready}, 64'd1);
    chk("mrst.idx0", {32'd0, out_index_0}, 64'd0);
    chk("mrst.idx1", {32'd0, out_index_1}, 64'd0);
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    accept(32'd256, 32'd972);
    wait_done();
    check_result("mrst.next", 32'd4, 32'd4, 1'b1, 1'b0);
    release_result(0);

    // Back-to-back with in_valid and out_ready held high
    bq0 = '{32'd1024, 32'd1536, 32'd2047};
    bq1 = '{32'd729, 32'd243, 32'd1458};
    sent = 0; got = 0; cyc = 0;
    out_ready = 1'b1;
    in_valid  = 1'b1;
    in_point_0 = bq0[0];
    in_point_1 = bq1[0];
    while (got < 3 && cyc < 200) begin
      if (out_valid) begin
        check_result($sformatf("b2b%0d", got), ref_index(bq0[got], B0, S0),
                     ref_index(bq1[got], B1, S1),
                     ref_index(bq0[got], B0, S0) == ref_index(bq1[got], B1, S1), 1'b0);
        got++;
      end
      if (in_ready) begin
        if (sent < 3) begin
          in_valid   = 1'b1;
          in_point_0 = bq0[sent];
          in_point_1 = bq1[sent];
          acc_cyc[sent] = cyc;
          sent++;
        end else begin
          in_valid = 1'b0;
        end
      end
      @(negedge clk);
      cyc++;
    end
    in_valid  = 1'b0;
    out_ready = 1'b0;
    chk("b2b.count", 64'(got), 64'd3);
    chk("b2b.gap01", 64'(acc_cyc[1] - acc_cyc[0]), 64'(SMAX + 2));
    chk("b2b.gap12", 64'(acc_cyc[2] - acc_cyc[1]), 64'(SMAX + 2));
    @(negedge clk);

    // Randomized points against the digit model
    for (int i = 0; i < 30; i++) begin
      p0 = ($urandom_range(3, 0) == 0) ? $urandom : ($urandom % 32'd2048);
      p1 = ($urandom_range(3, 0) == 0) ? $urandom : ($urandom % 32'd2187);
      k0 = ref_index(p0, B0, S0);
      k1 = ref_index(p1, B1, S1);
      accept(p0, p1);
      wait_done();
      check_result($sformatf("rnd%0d", i), k0, k1, k0 == k1, ref_err(p0, p1));
      release_result($urandom_range(3, 0));
    end

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
